// File: rtl/id_ctr_stage_pkg.sv
// Shared definitions for the LA32R decode stage.
// - Control-word field layout as a packed struct. The declaration order fixes the bit positions:
//   [3:0] type, [7:4] subop, [8] wb_en, [9] alu2_imm, [10] alu1_pc, [15:11] rd,
//   [16] jump, [17] branch, [21:18] aluop, [26:22] rj, [31:27] rk.
// - Instruction type and ALU operation encodings.
// - Opcode match constants, grouped by how many leading instruction bits identify the format.
package id_ctr_stage_pkg;

  typedef enum logic [3:0] {
    TYPE_ALU_R   = 4'd0,
    TYPE_BRANCH  = 4'd1,
    TYPE_LOAD    = 4'd3,
    TYPE_STORE   = 4'd4,
    TYPE_ALU_I   = 4'd8,
    TYPE_INVALID = 4'd15
  } ctr_type_e;

  typedef enum logic [3:0] {
    ALUOP_AND   = 4'd0,
    ALUOP_OR    = 4'd1,
    ALUOP_NOR   = 4'd2,
    ALUOP_XOR   = 4'd3,
    ALUOP_ADD   = 4'd4,
    ALUOP_SUB   = 4'd5,
    ALUOP_SLL   = 4'd6,
    ALUOP_SRL   = 4'd7,
    ALUOP_SRA   = 4'd8,
    ALUOP_SLT   = 4'd9,
    ALUOP_SLTU  = 4'd10,
    ALUOP_PASS1 = 4'd11,
    ALUOP_PASS2 = 4'd12,
    ALUOP_LINK  = 4'd13   // alu1 + 4, the return address
  } aluop_e;

  typedef struct packed {
    logic [4:0] rk;
    logic [4:0] rj;
    aluop_e     aluop;
    logic       branch;
    logic       jump;
    logic [4:0] rd;
    logic       alu1_pc;
    logic       alu2_imm;
    logic       wb_en;
    logic [3:0] subop;
    ctr_type_e  typ;
  } ctr_t;

  typedef struct packed {
    ctr_t        ctr;
    logic [31:0] imm;
    logic [31:0] pc;
  } entry_t;

  // inst[31:15]: 3R formats and the ui5 shifts.
  localparam logic [16:0] OP_ADD_W  = 17'h00020;
  localparam logic [16:0] OP_SUB_W  = 17'h00022;
  localparam logic [16:0] OP_SLT    = 17'h00024;
  localparam logic [16:0] OP_SLTU   = 17'h00025;
  localparam logic [16:0] OP_NOR    = 17'h00028;
  localparam logic [16:0] OP_AND    = 17'h00029;
  localparam logic [16:0] OP_OR     = 17'h0002a;
  localparam logic [16:0] OP_XOR    = 17'h0002b;
  localparam logic [16:0] OP_SLL_W  = 17'h0002e;
  localparam logic [16:0] OP_SRL_W  = 17'h0002f;
  localparam logic [16:0] OP_SRA_W  = 17'h00030;
  localparam logic [16:0] OP_SLLI_W = 17'h00081;
  localparam logic [16:0] OP_SRLI_W = 17'h00089;
  localparam logic [16:0] OP_SRAI_W = 17'h00091;
  // inst[31:22]: 2RI12 formats.
  localparam logic [9:0]  OP_SLTI   = 10'h008;
  localparam logic [9:0]  OP_SLTUI  = 10'h009;
  localparam logic [9:0]  OP_ADDI_W = 10'h00a;
  localparam logic [9:0]  OP_ANDI   = 10'h00d;
  localparam logic [9:0]  OP_ORI    = 10'h00e;
  localparam logic [9:0]  OP_XORI   = 10'h00f;
  localparam logic [9:0]  OP_LD_W   = 10'h0a2;
  localparam logic [9:0]  OP_ST_W   = 10'h0a6;
  // inst[31:25]: 1RI20 formats.
  localparam logic [6:0]  OP_LU12I  = 7'h0a;
  localparam logic [6:0]  OP_PCADDU = 7'h0e;
  // inst[31:26]: jumps and branches.
  localparam logic [5:0]  OP_JIRL   = 6'h13;
  localparam logic [5:0]  OP_B      = 6'h14;
  localparam logic [5:0]  OP_BL     = 6'h15;
  localparam logic [5:0]  OP_BEQ    = 6'h16;
  localparam logic [5:0]  OP_BGEU   = 6'h1b;

endpackage

// File: rtl/id_ctr_stage_if.sv
// Handshake bundle between IF, the decode stage and EX.
//   flush                         : squash everything held by the stage
//   in_valid/in_ready/in_inst/in_pc : fetched instruction offered by IF
//   out_valid/out_ready/out_ctr/out_imm/out_pc : decoded entry offered to EX
// master = pipeline side driving the stage, slave = the decode stage itself.
interface id_ctr_stage_if;
  import id_ctr_stage_pkg::*;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  ctr_t        out_ctr;
  logic [31:0] out_imm;
  logic [31:0] out_pc;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_ctr, out_imm, out_pc
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_ctr, out_imm, out_pc
  );
endinterface

// File: rtl/id_ctr_stage_inst_decode_comb.sv
// inst_decode_comb: pure combinational LA32R decoder.
//   inst : 32-bit instruction word (in)
//   ctr  : 32-bit control word (out)
//   imm  : sign/zero-extended immediate (out)
// Unrecognised words decode to type 15 with every other field zero.
module inst_decode_comb
  import id_ctr_stage_pkg::*;
(
  input  logic [31:0] inst,
  output ctr_t        ctr,
  output logic [31:0] imm
);

  ctr_t        c;
  logic        hit;
  logic [31:0] si12, ui12, hi20, off16, off26;

  assign si12  = {{20{inst[21]}}, inst[21:10]};
  assign ui12  = {20'd0, inst[21:10]};
  assign hi20  = {inst[24:5], 12'd0};
  assign off16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign off26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

  // NOTE: every variable written here gets its default first and is assigned with '=' so the
  // block stays purely combinational; a path that skipped an assignment would infer a latch.
  always_comb begin
    c       = '0;
    imm     = '0;
    hit     = 1'b1;
    c.rd    = inst[4:0];
    c.rj    = inst[9:5];
    c.rk    = inst[14:10];
    c.wb_en = 1'b1;

    case (inst[31:15])
      OP_ADD_W:  c.aluop = ALUOP_ADD;
      OP_SUB_W:  c.aluop = ALUOP_SUB;
      OP_SLT:    c.aluop = ALUOP_SLT;
      OP_SLTU:   c.aluop = ALUOP_SLTU;
      OP_NOR:    c.aluop = ALUOP_NOR;
      OP_AND:    c.aluop = ALUOP_AND;
      OP_OR:     c.aluop = ALUOP_OR;
      OP_XOR:    c.aluop = ALUOP_XOR;
      OP_SLL_W:  c.aluop = ALUOP_SLL;
      OP_SRL_W:  c.aluop = ALUOP_SRL;
      OP_SRA_W:  c.aluop = ALUOP_SRA;
      OP_SLLI_W: begin c.typ = TYPE_ALU_I; c.aluop = ALUOP_SLL; c.alu2_imm = 1'b1; imm = {27'd0, inst[14:10]}; end
      OP_SRLI_W: begin c.typ = TYPE_ALU_I; c.aluop = ALUOP_SRL; c.alu2_imm = 1'b1; imm = {27'd0, inst[14:10]}; end
      OP_SRAI_W: begin c.typ = TYPE_ALU_I; c.aluop = ALUOP_SRA; c.alu2_imm = 1'b1; imm = {27'd0, inst[14:10]}; end
      default:   hit = 1'b0;
    endcase

    if (!hit) begin
      hit        = 1'b1;
      c.typ      = TYPE_ALU_I;
      c.alu2_imm = 1'b1;
      case (inst[31:22])
        OP_SLTI:   begin c.aluop = ALUOP_SLT;  imm = si12; end
        OP_SLTUI:  begin c.aluop = ALUOP_SLTU; imm = si12; end
        OP_ADDI_W: begin c.aluop = ALUOP_ADD;  imm = si12; end
        OP_ANDI:   begin c.aluop = ALUOP_AND;  imm = ui12; end
        OP_ORI:    begin c.aluop = ALUOP_OR;   imm = ui12; end
        OP_XORI:   begin c.aluop = ALUOP_XOR;  imm = ui12; end
        OP_LD_W:   begin c.typ = TYPE_LOAD; c.aluop = ALUOP_ADD; imm = si12; end
        OP_ST_W:   begin
          c.typ = TYPE_STORE; c.aluop = ALUOP_ADD; imm = si12;
          c.wb_en = 1'b0; c.rk = inst[4:0];  // store data register travels in the rk slot
        end
        default:   hit = 1'b0;
      endcase
    end

    if (!hit) begin
      hit = 1'b1;
      case (inst[31:25])
        OP_LU12I:  begin c.aluop = ALUOP_PASS2; imm = hi20; end
        OP_PCADDU: begin c.aluop = ALUOP_ADD; c.alu1_pc = 1'b1; imm = hi20; end
        default:   hit = 1'b0;
      endcase
    end

    if (!hit) begin
      hit        = 1'b1;
      c.alu2_imm = 1'b0;
      case (inst[31:26])
        OP_JIRL: begin c.aluop = ALUOP_LINK; c.alu1_pc = 1'b1; c.jump = 1'b1; imm = off16; end
        OP_BL:   begin
          c.aluop = ALUOP_LINK; c.alu1_pc = 1'b1; c.jump = 1'b1; imm = off26;
          c.rd = 5'd1;  // bl links into r1 implicitly
        end
        OP_B:    begin c.typ = TYPE_BRANCH; c.jump = 1'b1; c.wb_en = 1'b0; c.rk = inst[4:0]; imm = off26; end
        default: begin
          if (inst[31:26] >= OP_BEQ && inst[31:26] <= OP_BGEU) begin
            // beq..bgeu are consecutive opcodes, so subop = opcode - beq + 1
            c.typ    = TYPE_BRANCH;
            c.branch = 1'b1;
            c.subop  = 4'(inst[31:26] - OP_BEQ + 6'd1);
            c.wb_en  = 1'b0;
            c.rk     = inst[4:0];
            imm      = off16;
          end else begin
            hit = 1'b0;
          end
        end
      endcase
    end

    if (!hit) begin
      c     = '0;
      c.typ = TYPE_INVALID;
      imm   = '0;
    end

    if (c.rd == 5'd0) c.wb_en = 1'b0;  // r0 is hard-wired to zero
    ctr = c;
  end

endmodule

// File: rtl/id_ctr_stage.sv
// id_ctr_stage: LA32R decode stage feeding the ID/EX slot.
//   clk      : clock, all state on posedge
//   rstn     : synchronous active-low reset
//   bus      : id_ctr_stage_if.slave (flush, IF-side in_* handshake, EX-side out_* handshake)
// One output slot plus a one-entry skid buffer; in_ready is the registered "skid empty" flag,
// so it never depends combinationally on out_ready.
module id_ctr_stage
  import id_ctr_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic           clk,
  input  logic           rstn,
  id_ctr_stage_if.slave  bus
);

  entry_t slot, skid, dec;
  logic   slot_valid, skid_valid;
  logic   in_fire, slot_free;

  inst_decode_comb u_decode (
    .inst (bus.in_inst),
    .ctr  (dec.ctr),
    .imm  (dec.imm)
  );
  assign dec.pc = bus.in_pc;

  assign in_fire   = bus.in_valid & ~skid_valid;
  assign slot_free = ~slot_valid | bus.out_ready;

  // NOTE: sequential state is written only with '<=' so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (slot_free) begin
      // A full skid implies in_ready was low, so no new beat competes with the drain.
      slot_valid <= skid_valid | in_fire;
      skid_valid <= 1'b0;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
    end
  end

  // Slot payload loads only when an entry actually moves in, so bubbles do not toggle it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot.ctr <= '0;
      slot.imm <= '0;
      slot.pc  <= RESET_PC;
    end else if (!bus.flush && slot_free) begin
      if (skid_valid)   slot <= skid;
      else if (in_fire) slot <= dec;
    end
  end

  // NOTE: the skid payload has no reset; skid_valid alone decides whether it means anything.
  always_ff @(posedge clk) begin
    if (in_fire && !slot_free) skid <= dec;
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = slot_valid;
  assign bus.out_ctr   = slot.ctr;
  assign bus.out_imm   = slot.imm;
  assign bus.out_pc    = slot_valid ? slot.pc : RESET_PC;

endmodule

// File: tb/tb_id_ctr_stage.sv
module tb_id_ctr_stage;
  import id_ctr_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int NT = 33;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_ctr_stage_if bus ();

  id_ctr_stage #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Directed vectors: inst, expected ctr, expected imm (hand-computed).
  logic [31:0] d_inst [7] = '{32'h00100823, 32'h02bffc01, 32'h142468a4, 32'h00100820,
                              32'h58000822, 32'h54000400, 32'h00000000};
  logic [31:0] d_ctr  [7] = '{32'h10501900, 32'hf8100b08, 32'hd1702308, 32'h10500000,
                              32'h10421011, 32'h08350d08, 32'h0000000f};
  logic [31:0] d_imm  [7] = '{32'h00000000, 32'hffffffff, 32'h12345000, 32'h00000000,
                              32'h00000008, 32'h00000004, 32'h00000000};

  // Reference decoder table: opcode pattern, type, aluop, immediate kind, flags (1 alu2_imm,
  // 2 alu1_pc, 4 jump, 8 branch). Immediate kinds: 0 none, 1 ui5, 2 si12, 3 ui12, 4 si20<<12,
  // 5 offs16<<2, 6 offs26<<2.
  logic [31:0] t_val [NT] = '{
    32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00140000, 32'h00148000,
    32'h00150000, 32'h00158000, 32'h00170000, 32'h00178000, 32'h00180000, 32'h00408000,
    32'h00448000, 32'h00488000, 32'h02000000, 32'h02400000, 32'h02800000, 32'h03400000,
    32'h03800000, 32'h03c00000, 32'h28800000, 32'h29800000, 32'h14000000, 32'h1c000000,
    32'h4c000000, 32'h50000000, 32'h54000000, 32'h58000000, 32'h5c000000, 32'h60000000,
    32'h64000000, 32'h68000000, 32'h6c000000};
  int t_ty  [NT] = '{0,0,0,0,0,0,0,0,0,0,0, 8,8,8, 8,8,8,8,8,8, 3,4, 8,8, 8,1,8, 1,1,1,1,1,1};
  int t_aop [NT] = '{4,5,9,10,2,0,1,3,6,7,8, 6,7,8, 9,10,4,0,1,3, 4,4, 12,4, 13,0,13, 0,0,0,0,0,0};
  int t_imm [NT] = '{0,0,0,0,0,0,0,0,0,0,0, 1,1,1, 2,2,2,3,3,3, 2,2, 4,4, 5,6,6, 5,5,5,5,5,5};
  int t_fl  [NT] = '{0,0,0,0,0,0,0,0,0,0,0, 1,1,1, 1,1,1,1,1,1, 1,1, 1,3, 6,4,6, 8,8,8,8,8,8};

  function automatic logic [31:0] mask_of(input int k);
    if (k < 14)      return 32'hffff8000;
    else if (k < 22) return 32'hffc00000;
    else if (k < 24) return 32'hfe000000;
    else             return 32'hfc000000;
  endfunction

  function automatic void ref_decode(input logic [31:0] w, output logic [31:0] ctr,
                                     output logic [31:0] imm);
    int hit = -1;
    logic [31:0] ty, aop, fl, sub, rd, rj, rk, wb;
    for (int k = 0; k < NT; k++)
      if ((w & mask_of(k)) == t_val[k]) hit = k;
    ctr = 32'h0000000f;
    imm = 32'h0;
    if (hit < 0) return;
    ty  = 32'(t_ty[hit]);
    aop = 32'(t_aop[hit]);
    fl  = 32'(t_fl[hit]);
    sub = (hit >= 27) ? 32'(hit - 26) : 32'd0;
    rd  = (hit == 26) ? 32'd1 : {27'd0, w[4:0]};
    rj  = {27'd0, w[9:5]};
    rk  = (ty == 1 || ty == 4) ? {27'd0, w[4:0]} : {27'd0, w[14:10]};
    wb  = ((ty == 0 || ty == 8 || ty == 3) && rd != 0) ? 32'd1 : 32'd0;
    case (t_imm[hit])
      1:       imm = {27'd0, w[14:10]};
      2:       imm = {{20{w[21]}}, w[21:10]};
      3:       imm = {20'd0, w[21:10]};
      4:       imm = {w[24:5], 12'd0};
      5:       imm = {{14{w[25]}}, w[25:10], 2'b00};
      6:       imm = {{4{w[9]}}, w[9:0], w[25:10], 2'b00};
      default: imm = 32'h0;
    endcase
    ctr = (rk << 27) | (rj << 22) | (aop << 18) | (((fl >> 3) & 1) << 17) | (((fl >> 2) & 1) << 16)
        | (rd << 11) | (((fl >> 1) & 1) << 10) | ((fl & 1) << 9) | (wb << 8) | (sub << 4) | ty;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    bus.in_valid = 1'b1;
    bus.in_inst  = i;
    bus.in_pc    = p;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_ctr"},   bus.out_ctr,        32'h0);
    check({tag, "_out_imm"},   bus.out_imm,        32'h0);
    check({tag, "_out_pc"},    bus.out_pc,         RESET_PC);
  endtask

  initial begin
    logic [31:0] w, ec, ei, pc;
    int k;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b1;

    step(); step();
    check_reset("rst");
    rstn = 1'b1;

    // Directed decode, one-cycle latency, entry consumed immediately.
    for (int n = 0; n < 7; n++) begin
      drive(d_inst[n], 32'h1c000100 + 32'(n * 4));
      step();
      bus.in_valid = 1'b0;
      check($sformatf("dir%0d_valid", n), 32'(bus.out_valid), 32'd1);
      check($sformatf("dir%0d_ctr", n),   bus.out_ctr,        d_ctr[n]);
      check($sformatf("dir%0d_imm", n),   bus.out_imm,        d_imm[n]);
      check($sformatf("dir%0d_pc", n),    bus.out_pc,         32'h1c000100 + 32'(n * 4));
    end
    step();
    check("bubble_valid", 32'(bus.out_valid), 32'd0);
    check("bubble_pc",    bus.out_pc,         RESET_PC);

    // Backpressure: three beats offered while EX stalls.
    bus.out_ready = 1'b0;
    drive(d_inst[0], 32'h1000); step();
    check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp1_pc",       bus.out_pc,        32'h1000);
    drive(d_inst[1], 32'h1004); step();
    check("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp2_pc",       bus.out_pc,        32'h1000);
    check("bp2_ctr",      bus.out_ctr,       d_ctr[0]);
    drive(d_inst[2], 32'h1008); step();
    check("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp3_pc",       bus.out_pc,        32'h1000);
    bus.out_ready = 1'b1; step();
    check("bp4_pc",       bus.out_pc,        32'h1004);
    check("bp4_ctr",      bus.out_ctr,       d_ctr[1]);
    check("bp4_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("bp5_pc",       bus.out_pc,        32'h1008);
    check("bp5_ctr",      bus.out_ctr,       d_ctr[2]);
    bus.in_valid = 1'b0; step();
    check("bp6_valid",    32'(bus.out_valid), 32'd0);

    // Flush with slot and skid full and a new beat offered.
    bus.out_ready = 1'b0;
    drive(d_inst[0], 32'h2000); step();
    drive(d_inst[1], 32'h2004); step();
    check("fl_pre_in_ready", 32'(bus.in_ready), 32'd0);
    drive(d_inst[2], 32'h2008);
    bus.flush = 1'b1; step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("fl_valid",    32'(bus.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1; step();
    check("fl_post1_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("fl_post2_valid", 32'(bus.out_valid), 32'd0);

    // Random legal and illegal words against the reference decoder.
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, NT));
      w = $urandom;
      if (k < NT) w = (w & ~mask_of(k)) | t_val[k];
      pc = $urandom & 32'hfffffffc;
      ref_decode(w, ec, ei);
      drive(w, pc); step();
      check($sformatf("rnd%0d_ctr_%h", n, w), bus.out_ctr, ec);
      check($sformatf("rnd%0d_imm_%h", n, w), bus.out_imm, ei);
    end
    bus.in_valid = 1'b0; step();

    // Reset while stalled with slot and skid full.
    bus.out_ready = 1'b0;
    drive(d_inst[3], 32'h3000); step();
    drive(d_inst[4], 32'h3004); step();
    bus.in_valid = 1'b0;
    rstn = 1'b0; step();
    check_reset("rst_stall");
    rstn = 1'b1; bus.out_ready = 1'b1; step();
    check("rst_post_valid", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
